// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state type, port indices and default widths for the data-memory arbiter
package dmem_arb_pkg;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_LOAD = 1'b1;
    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;
    localparam int DEF_MAX_HOLD = 16;
endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick, one-hot grant; a tie goes to the port that did not win last
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] gnt
);
    assign gnt[0] = valid0 & (~valid1 | (last_grant == PORT_LOAD));
    assign gnt[1] = valid1 & (~valid0 | (last_grant == PORT_CORE));
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the core (port 0) and the loader (port 1)
// Optional forced release of long locks: define DMEM_ARB_HOLD_LIMIT_EN
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_valid,
    input  logic          p0_we,
    input  logic          p0_lock,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ready,
    output logic          p0_rsp_valid,
    output logic [DW-1:0] p0_rsp_rdata,
    input  logic          p1_valid,
    input  logic          p1_we,
    input  logic          p1_lock,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ready,
    output logic          p1_rsp_valid,
    output logic [DW-1:0] p1_rsp_rdata,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd,
    output logic          busy
);
    state_t state, state_nxt;
    logic last_grant, last_nxt;
    logic [1:0] pick, gnt;
    logic rd0, rd1, force_rel;

    if (MAX_HOLD < 2) begin : g_hold_check
        $error("dmem_arbiter: MAX_HOLD must be at least 2");
    end

    rr_pick2 u_pick (
        .valid0    (p0_valid),
        .valid1    (p1_valid),
        .last_grant(last_grant),
        .gnt       (pick)
    );

    // an owning port is granted only while it is actually requesting
    assign gnt = (state == OWN0) ? {1'b0, p0_valid} :
                 (state == OWN1) ? {p1_valid, 1'b0} : pick;
    assign p0_ready = gnt[0] & p0_valid;
    assign p1_ready = gnt[1] & p1_valid;
    assign mem_a = gnt[0] ? p0_addr : gnt[1] ? p1_addr : '0;
    assign mem_wd = gnt[0] ? p0_wdata : gnt[1] ? p1_wdata : '0;
    assign mem_we = (p0_ready & p0_we) | (p1_ready & p1_we);
    assign busy = state != IDLE;
    assign rd0 = p0_ready & ~p0_we;
    assign rd1 = p1_ready & ~p1_we;

`ifdef DMEM_ARB_HOLD_LIMIT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
    logic [CW-1:0] hold_cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            hold_cnt <= '0;
        else if (state == IDLE)
            hold_cnt <= '0;
        else if (hold_cnt != HOLD_LAST)
            hold_cnt <= hold_cnt + 1'b1;
    end
    assign force_rel = (hold_cnt == HOLD_LAST) &&
                       (((state == OWN0) && p1_valid) || ((state == OWN1) && p0_valid));
`else
    assign force_rel = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        last_nxt = p0_ready ? PORT_CORE : p1_ready ? PORT_LOAD : last_grant;
        case (state)
            IDLE: state_nxt = (p0_ready & p0_lock) ? OWN0 : (p1_ready & p1_lock) ? OWN1 : IDLE;
            OWN0: if (!p0_lock || force_rel) begin
                state_nxt = IDLE;
                last_nxt = PORT_CORE;
            end
            OWN1: if (!p1_lock || force_rel) begin
                state_nxt = IDLE;
                last_nxt = PORT_LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            last_grant <= PORT_LOAD;
        end else begin
            state <= state_nxt;
            last_grant <= last_nxt;
        end
    end

    // reset drops any response whose read was accepted in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p0_rsp_valid <= 1'b0;
            p1_rsp_valid <= 1'b0;
            p0_rsp_rdata <= '0;
            p1_rsp_rdata <= '0;
        end else begin
            p0_rsp_valid <= rd0;
            p1_rsp_valid <= rd1;
            if (rd0)
                p0_rsp_rdata <= mem_rd;
            if (rd1)
                p1_rsp_rdata <= mem_rd;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table, hand sequences and a randomized run against a rule-level model
module tb_dmem_arbiter;
    localparam int MH = 4;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef struct {
        logic v0, w0, l0; logic [7:0] a0; logic [31:0] d0;
        logic v1, w1, l1; logic [7:0] a1; logic [31:0] d1;
        logic r0, r1, we, busy; logic [7:0] a; logic [31:0] wd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic p0_valid, p0_we, p0_lock, p0_ready, p0_rsp_valid;
    logic [31:0] p0_addr, p0_wdata, p0_rsp_rdata;
    logic p1_valid, p1_we, p1_lock, p1_ready, p1_rsp_valid;
    logic [31:0] p1_addr, p1_wdata, p1_rsp_rdata;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic mem_we, busy;

    logic [31:0] mem_arr [64];
    logic [31:0] ref_mem [64];
    logic pl_en = 1'b0;
    logic [5:0] pl_idx = '0;
    logic [31:0] pl_val = '0;
    int checks = 0;
    int failures = 0;
    vec_t tbl [15];

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_ready(p0_ready), .p0_rsp_valid(p0_rsp_valid),
        .p0_rsp_rdata(p0_rsp_rdata),
        .p1_valid(p1_valid), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ready(p1_ready), .p1_rsp_valid(p1_rsp_valid),
        .p1_rsp_rdata(p1_rsp_rdata),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd), .busy(busy)
    );

    assign mem_rd = mem_arr[mem_a[7:2]];

    always @(posedge clk) begin
        if (pl_en)
            mem_arr[pl_idx] <= pl_val;
        else if (mem_we)
            mem_arr[mem_a[7:2]] <= mem_wd;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic w0, input logic l0, input logic [31:0] a0,
                         input logic [31:0] d0, input logic v1, input logic w1, input logic l1,
                         input logic [31:0] a1, input logic [31:0] d1);
        p0_valid = v0; p0_we = w0; p0_lock = l0; p0_addr = a0; p0_wdata = d0;
        p1_valid = v1; p1_we = w1; p1_lock = l1; p1_addr = a1; p1_wdata = d1;
    endtask

    task automatic idle();
        drive(L, L, L, 32'h0, 32'h0, L, L, L, 32'h0, 32'h0);
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx[5:0]; pl_val = val;
        ref_mem[idx] = val;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{H,L,L,8'h08,32'h55, H,L,L,8'h0C,32'h100, H,L,L,L,8'h08,32'h55};
        tbl[1]  = '{H,L,L,8'h08,32'h55, H,L,L,8'h0C,32'h100, L,H,L,L,8'h0C,32'h100};
        tbl[2]  = tbl[0];
        tbl[3]  = tbl[1];
        tbl[4]  = '{H,H,L,8'h20,32'h55, L,L,L,8'h00,32'h0,   H,L,H,L,8'h20,32'h55};
        tbl[5]  = '{H,L,L,8'h08,32'h55, H,H,H,8'h00,32'h11,  L,H,H,L,8'h00,32'h11};
        tbl[6]  = '{H,L,L,8'h08,32'h55, H,H,H,8'h04,32'h22,  L,H,H,H,8'h04,32'h22};
        tbl[7]  = '{H,L,L,8'h08,32'h55, H,H,H,8'h08,32'h33,  L,H,H,H,8'h08,32'h33};
        tbl[8]  = '{H,L,L,8'h08,32'h55, H,H,L,8'h0C,32'h44,  L,H,H,H,8'h0C,32'h44};
        tbl[9]  = '{H,L,L,8'h08,32'h55, H,H,L,8'h10,32'h66,  H,L,L,L,8'h08,32'h55};
        tbl[10] = '{L,L,L,8'h00,32'h0,  H,H,H,8'h30,32'h77,  L,H,H,L,8'h30,32'h77};
        tbl[11] = '{H,L,L,8'h08,32'h55, L,L,H,8'h00,32'h0,   L,L,L,H,8'h00,32'h0};
        tbl[12] = tbl[11];
        tbl[13] = '{H,L,L,8'h08,32'h55, L,L,L,8'h00,32'h0,   L,L,L,H,8'h00,32'h0};
        tbl[14] = '{H,L,L,8'h08,32'h55, L,L,L,8'h00,32'h0,   H,L,L,L,8'h08,32'h55};

        idle();
        repeat (2) @(negedge clk);
        chk("reset.busy", busy, 0);
        chk("reset.p0_rsp_valid", p0_rsp_valid, 0);
        chk("reset.p1_rsp_valid", p1_rsp_valid, 0);
        chk("reset.p0_rsp_rdata", p0_rsp_rdata, 0);
        chk("reset.p1_rsp_rdata", p1_rsp_rdata, 0);
        chk("reset.mem_we", mem_we, 0);
        chk("reset.mem_a", mem_a, 0);
        preload(4, 32'hDEADBEEF);
        preload(5, 32'h12345678);
        rst = 1'b1;

        // single read, then back-to-back reads on the same port
        @(negedge clk);
        drive(H, L, L, 32'h10, 32'h0, L, L, L, 32'h0, 32'h0);
        #1;
        chk("rd.p0_ready", p0_ready, 1);
        chk("rd.p1_ready", p1_ready, 0);
        chk("rd.busy", busy, 0);
        chk("rd.mem_a", mem_a, 32'h10);
        chk("rd.mem_we", mem_we, 0);
        @(posedge clk); #1;
        chk("rd.p0_rsp_valid", p0_rsp_valid, 1);
        chk("rd.p0_rsp_rdata", p0_rsp_rdata, 32'hDEADBEEF);
        @(negedge clk);
        drive(H, L, L, 32'h14, 32'h0, L, L, L, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("b2b.p0_rsp_valid", p0_rsp_valid, 1);
        chk("b2b.p0_rsp_rdata", p0_rsp_rdata, 32'h12345678);
        @(negedge clk);
        idle();
        @(posedge clk); #1;
        chk("pulse.p0_rsp_valid", p0_rsp_valid, 0);
        chk("hold.p0_rsp_rdata", p0_rsp_rdata, 32'h12345678);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(tbl[i].v0, tbl[i].w0, tbl[i].l0, {24'h0, tbl[i].a0}, tbl[i].d0,
                  tbl[i].v1, tbl[i].w1, tbl[i].l1, {24'h0, tbl[i].a1}, tbl[i].d1);
            #1;
            chk($sformatf("vec%0d.p0_ready", i), p0_ready, tbl[i].r0);
            chk($sformatf("vec%0d.p1_ready", i), p1_ready, tbl[i].r1);
            chk($sformatf("vec%0d.mem_we", i), mem_we, tbl[i].we);
            chk($sformatf("vec%0d.busy", i), busy, tbl[i].busy);
            chk($sformatf("vec%0d.mem_a", i), mem_a, {24'h0, tbl[i].a});
            chk($sformatf("vec%0d.mem_wd", i), mem_wd, tbl[i].wd);
            @(posedge clk); #1;
            chk($sformatf("vec%0d.p0_rsp_valid", i), p0_rsp_valid, tbl[i].r0 & ~tbl[i].w0);
            chk($sformatf("vec%0d.p1_rsp_valid", i), p1_rsp_valid, tbl[i].r1 & ~tbl[i].w1);
        end

        // asynchronous reset while port 1 owns the memory with a read in flight
        do_reset();
        @(negedge clk);
        drive(L, L, L, 32'h0, 32'h0, H, H, H, 32'h40, 32'hAB);
        #1;
        chk("arst.p1_ready", p1_ready, 1);
        @(negedge clk);
        drive(H, L, L, 32'h08, 32'h0, H, L, H, 32'h40, 32'h0);
        #1;
        chk("arst.busy_locked", busy, 1);
        chk("arst.p0_stalled", p0_ready, 0);
        @(posedge clk); #1;
        chk("arst.p1_rsp_valid", p1_rsp_valid, 1);
        chk("arst.p1_rsp_rdata", p1_rsp_rdata, 32'hAB);
        @(negedge clk);
        drive(L, L, L, 32'h0, 32'h0, H, L, H, 32'h44, 32'h0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst.busy", busy, 0);
        chk("arst.p1_rsp_valid_now", p1_rsp_valid, 0);
        chk("arst.p0_rsp_valid_now", p0_rsp_valid, 0);
        @(negedge clk);
        idle();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk($sformatf("arst.no_late%0d", k), p1_rsp_valid, 0);
            chk($sformatf("arst.idle%0d", k), busy, 0);
        end

`ifdef DMEM_ARB_HOLD_LIMIT_EN
        do_reset();
        @(negedge clk);
        drive(L, L, L, 32'h0, 32'h0, H, H, H, 32'h80, 32'h1);
        #1;
        chk("hlim.p1_first", p1_ready, 1);
        begin
            int n1;
            logic got;
            n1 = 0;
            got = 1'b0;
            for (int k = 0; k < 3 * MH && !got; k++) begin
                @(negedge clk);
                drive(H, L, L, 32'h08, 32'h0, H, H, H, 32'h84, 32'h2);
                #1;
                if (p0_ready)
                    got = 1'b1;
                else if (p1_ready)
                    n1++;
            end
            chk("hlim.p0_granted", got, 1);
            chk("hlim.p1_beats", n1, MH);
        end
`endif

        do_reset();
        for (int i = 0; i < 64; i++)
            preload(i, $urandom);
        begin
            int own, last, cnt, g;
            logic forced, er0, er1;
            logic [1:0] v, w, l;
            logic [7:0] a [2];
            logic [31:0] d [2];
            logic [31:0] erd0, erd1;
            own = -1;
            last = 1;
            cnt = 0;
            for (int n = 0; n < 400; n++) begin
                for (int p = 0; p < 2; p++) begin
                    v[p] = $urandom_range(0, 3) != 0;
                    w[p] = $urandom_range(0, 1) != 0;
                    l[p] = $urandom_range(0, 3) != 0;
                    a[p] = {6'($urandom_range(0, 63)), 2'b00};
                    d[p] = $urandom;
                end
                @(negedge clk);
                drive(v[0], w[0], l[0], {24'h0, a[0]}, d[0], v[1], w[1], l[1], {24'h0, a[1]}, d[1]);
                if (own >= 0)
                    g = v[own] ? own : -1;
                else if (v == 2'b11)
                    g = 1 - last;
                else
                    g = v[0] ? 0 : v[1] ? 1 : -1;
                #1;
                chk("rnd.p0_ready", p0_ready, g == 0);
                chk("rnd.p1_ready", p1_ready, g == 1);
                chk("rnd.mem_we", mem_we, g >= 0 && w[g]);
                chk("rnd.busy", busy, own >= 0);
                chk("rnd.mem_a", mem_a, g >= 0 ? {24'h0, a[g]} : 32'h0);
                if (g >= 0)
                    chk("rnd.mem_wd", mem_wd, d[g]);
                er0 = g == 0 && !w[0];
                er1 = g == 1 && !w[1];
                erd0 = ref_mem[a[0][7:2]];
                erd1 = ref_mem[a[1][7:2]];
`ifdef DMEM_ARB_HOLD_LIMIT_EN
                forced = own >= 0 && cnt == MH - 1 && v[1 - own];
`else
                forced = 1'b0;
`endif
                if (g >= 0 && w[g])
                    ref_mem[a[g][7:2]] = d[g];
                if (g >= 0)
                    last = g;
                if (own < 0) begin
                    cnt = 0;
                    if (g >= 0 && l[g])
                        own = g;
                end else begin
                    cnt = (cnt < MH - 1) ? cnt + 1 : cnt;
                    if (!l[own] || forced) begin
                        last = own;
                        own = -1;
                    end
                end
                @(posedge clk); #1;
                chk("rnd.p0_rsp_valid", p0_rsp_valid, er0);
                chk("rnd.p1_rsp_valid", p1_rsp_valid, er1);
                if (er0)
                    chk("rnd.p0_rsp_rdata", p0_rsp_rdata, erd0);
                if (er1)
                    chk("rnd.p1_rsp_rdata", p1_rsp_rdata, erd1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
